// File: rtl/memory_access_sequencer.sv
// memory_access_sequencer: multi-cycle data-RAM port controller that stalls the core while an access is in flight.
// Define MEMORY_PROTECTION_EN to reject out-of-range and protected user-mode accesses.
module memory_access_sequencer #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int CODE_AREA_SIZE = 4096,
    parameter int USER_STACK_TOP = 6144,
    parameter int DATA_AREA_SIZE = 8192,
    parameter int READ_LATENCY   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  privilege_mode_flag,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  fault,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int                   CNT_WIDTH = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT  = CNT_WIDTH'(READ_LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  accept;
    logic                  req_fault;

    assign accept = (state_q == IDLE) && req_valid;

`ifdef MEMORY_PROTECTION_EN
    localparam logic [31:0] CODE_LIMIT  = 32'(CODE_AREA_SIZE);
    localparam logic [31:0] STACK_LIMIT = 32'(USER_STACK_TOP);
    localparam logic [31:0] DATA_LIMIT  = 32'(DATA_AREA_SIZE);

    logic [31:0] addr_ext;
    logic        fault_q, fault_d;

    // The fault decision is made once at accept time and carried to the response cycle.
    always_comb begin
        addr_ext  = 32'(req_address);
        req_fault = (addr_ext >= DATA_LIMIT);
        if (!privilege_mode_flag) begin
            if (req_write && (addr_ext < CODE_LIMIT)) begin
                req_fault = 1'b1;
            end
            if ((addr_ext >= CODE_LIMIT) && (addr_ext < STACK_LIMIT)) begin
                req_fault = 1'b1;
            end
        end
        fault_d = fault_q;
        if (accept) begin
            fault_d = req_fault;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = resp_valid && fault_q;
`else
    assign req_fault = 1'b0;
    assign fault     = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        resp_rdata_d  = resp_rdata_q;
        cnt_d         = cnt_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_we        = 1'b0;
        stall         = 1'b1;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    mem_address_d = req_address;
                    mem_wdata_d   = req_wdata;
                    resp_rdata_d  = '0;
                    cnt_d         = CNT_INIT;
                    if (req_fault) begin
                        state_d = RESP;
                    end else if (req_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // Count 1 marks the cycle in which the RAM data is valid.
                if (cnt_q == CNT_ONE) begin
                    resp_rdata_d = mem_rdata;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WRITE: begin
                mem_we  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            resp_rdata_q  <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            resp_rdata_q  <= resp_rdata_d;
            cnt_q         <= cnt_d;
        end
    end

    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign resp_rdata  = resp_rdata_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// tb_memory_access_sequencer: directed bench with a response scoreboard and a registered-read RAM model.
// Expected fault behaviour follows MEMORY_PROTECTION_EN when it is defined for the build.
module tb_memory_access_sequencer;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int LAT = 2;
`ifdef MEMORY_PROTECTION_EN
    localparam logic PROT = 1'b1;
`else
    localparam logic PROT = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_address;
    logic [DW-1:0] req_wdata;
    logic          privilege_mode_flag;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          fault;
    logic          stall;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    typedef struct {
        string         tag;
        logic [DW-1:0] rdata;
        logic          fault;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] shadow[int];
    logic [DW-1:0] ram[0:(1 << AW) - 1];
    int            vectors     = 0;
    int            miscompares = 0;

    memory_access_sequencer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .CODE_AREA_SIZE(4096),
        .USER_STACK_TOP(6144),
        .DATA_AREA_SIZE(8192),
        .READ_LATENCY  (LAT)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_write          (req_write),
        .req_address        (req_address),
        .req_wdata          (req_wdata),
        .privilege_mode_flag(privilege_mode_flag),
        .req_ready          (req_ready),
        .resp_valid         (resp_valid),
        .resp_rdata         (resp_rdata),
        .fault              (fault),
        .stall              (stall),
        .mem_address        (mem_address),
        .mem_wdata          (mem_wdata),
        .mem_we             (mem_we),
        .mem_rdata          (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] memInit(input int idx);
        return 32'h5A5A0000 | 32'(idx);
    endfunction

    function automatic logic [DW-1:0] expectedRead(input logic [AW-1:0] addr);
        if (shadow.exists(int'(addr))) begin
            return shadow[int'(addr)];
        end
        return memInit(int'(addr));
    endfunction

    // One registered read stage: address seen in cycle N yields data in cycle N+1.
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = memInit(i);
        end
    end

    always @(posedge clock) begin
        if (mem_we === 1'b1) begin
            ram[mem_address] <= mem_wdata;
        end
        mem_rdata <= ram[mem_address];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.tag, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
                checkOutput({e.tag, "_fault"}, 64'(fault), 64'(e.fault));
            end
        end
    end

    // Issues one request from IDLE and checks timing cycle by cycle until the core is released.
    task automatic applyStimulus(input string tag, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic priv, input logic exp_fault);
        int   lat;
        exp_t e;
        lat = exp_fault ? 1 : (wr ? 2 : LAT + 1);
        @(negedge clock);
        req_valid           = 1'b1;
        req_write           = wr;
        req_address         = addr;
        req_wdata           = wdata;
        privilege_mode_flag = priv;
        #1;
        checkOutput({tag, "_accept_ready"}, 64'(req_ready), 64'd1);
        checkOutput({tag, "_accept_stall"}, 64'(stall), 64'd1);
        e.tag   = tag;
        e.fault = exp_fault;
        e.rdata = (wr || exp_fault) ? '0 : expectedRead(addr);
        sb.push_back(e);
        if (wr && !exp_fault) begin
            shadow[int'(addr)] = wdata;
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            req_valid = 1'b0;
            #1;
            checkOutput({tag, "_ready"}, 64'(req_ready), 64'd0);
            checkOutput({tag, "_stall"}, 64'(stall), 64'd1);
            checkOutput({tag, "_we"}, 64'(mem_we), 64'(wr && !exp_fault && (k == 1)));
            checkOutput({tag, "_resp_valid"}, 64'(resp_valid), 64'(k == lat));
            if (!exp_fault) begin
                checkOutput({tag, "_mem_addr"}, 64'(mem_address), 64'(addr));
            end
            if (wr && !exp_fault && (k == 1)) begin
                checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(wdata));
            end
        end
        @(negedge clock);
        #1;
        checkOutput({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
        checkOutput({tag, "_idle_stall"}, 64'(stall), 64'd0);
        checkOutput({tag, "_idle_resp"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] addr_cur;
        logic [DW-1:0] data_cur;
        logic [AW-1:0] last_acc;
        logic [AW-1:0] first_acc;
        exp_t          e;

        reset               = 1'b1;
        req_valid           = 1'b0;
        req_write           = 1'b0;
        req_address         = '0;
        req_wdata           = '0;
        privilege_mode_flag = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("rst_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_rdata", 64'(resp_rdata), 64'd0);
        checkOutput("rst_fault", 64'(fault), 64'd0);
        checkOutput("rst_stall", 64'(stall), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_address), 64'd0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        applyStimulus("wr_1900", 1'b1, 14'h1900, 32'hDEADBEEF, 1'b1, 1'b0);
        applyStimulus("rd_1900", 1'b0, 14'h1900, 32'h0, 1'b1, 1'b0);
        checkOutput("rd_1900_rdata_hold", 64'(resp_rdata), 64'hDEADBEEF);

        applyStimulus("usr_rd_1000", 1'b0, 14'h1000, 32'h0, 1'b0, PROT);
        applyStimulus("usr_wr_0010", 1'b1, 14'h0010, 32'h11111111, 1'b0, PROT);
        applyStimulus("prv_rd_0010", 1'b0, 14'h0010, 32'h0, 1'b1, 1'b0);
        applyStimulus("prv_wr_0010", 1'b1, 14'h0010, 32'h22222222, 1'b1, 1'b0);
        applyStimulus("usr_rd_0010", 1'b0, 14'h0010, 32'h0, 1'b0, 1'b0);
        applyStimulus("usr_wr_0fff", 1'b1, 14'h0FFF, 32'h33333333, 1'b0, PROT);
        applyStimulus("usr_rd_0fff", 1'b0, 14'h0FFF, 32'h0, 1'b0, 1'b0);
        applyStimulus("usr_rd_17ff", 1'b0, 14'h17FF, 32'h0, 1'b0, PROT);
        applyStimulus("prv_rd_17ff", 1'b0, 14'h17FF, 32'h0, 1'b1, 1'b0);
        applyStimulus("usr_wr_1800", 1'b1, 14'h1800, 32'h44444444, 1'b0, 1'b0);
        applyStimulus("usr_rd_1800", 1'b0, 14'h1800, 32'h0, 1'b0, 1'b0);
        applyStimulus("prv_rd_1fff", 1'b0, 14'h1FFF, 32'h0, 1'b1, 1'b0);
        applyStimulus("prv_rd_2000", 1'b0, 14'h2000, 32'h0, 1'b1, PROT);
        applyStimulus("usr_wr_2000", 1'b1, 14'h2000, 32'h55555555, 1'b0, PROT);
        applyStimulus("prv_rd_3fff", 1'b0, 14'h3FFF, 32'h0, 1'b1, PROT);
        applyStimulus("prv_rd_2000b", 1'b0, 14'h2000, 32'h0, 1'b1, PROT);

        // Reset lands one cycle into a read; that read must never respond.
        @(negedge clock);
        req_valid           = 1'b1;
        req_write           = 1'b0;
        req_address         = 14'h1900;
        privilege_mode_flag = 1'b1;
        #1;
        checkOutput("mid_rst_accept_stall", 64'(stall), 64'd1);
        @(negedge clock);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        checkOutput("mid_rst_busy_ready", 64'(req_ready), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_ready", 64'(req_ready), 64'd1);
        checkOutput("mid_rst_stall", 64'(stall), 64'd0);
        checkOutput("mid_rst_resp", 64'(resp_valid), 64'd0);
        checkOutput("mid_rst_rdata", 64'(resp_rdata), 64'd0);
        repeat (2) begin
            @(negedge clock);
            #1;
            checkOutput("mid_rst_no_resp", 64'(resp_valid), 64'd0);
        end
        applyStimulus("post_rst_wr", 1'b1, 14'h1A80, 32'hCAFEF00D, 1'b1, 1'b0);

        // Writes held back to back: accepts at every third cycle, new request ignored while busy.
        addr_cur  = 14'h1A00;
        data_cur  = 32'hC0DE0000;
        last_acc  = '0;
        first_acc = addr_cur;
        @(negedge clock);
        req_valid           = 1'b1;
        req_write           = 1'b1;
        privilege_mode_flag = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                @(negedge clock);
            end
            req_address = addr_cur;
            req_wdata   = data_cur;
            #1;
            checkOutput("btb_ready", 64'(req_ready), 64'((k % 3) == 0));
            checkOutput("btb_stall", 64'(stall), 64'd1);
            checkOutput("btb_we", 64'(mem_we), 64'((k % 3) == 1));
            checkOutput("btb_resp_valid", 64'(resp_valid), 64'((k % 3) == 2));
            if ((k % 3) == 1) begin
                checkOutput("btb_mem_addr", 64'(mem_address), 64'(last_acc));
            end
            if ((k % 3) == 0) begin
                e.tag   = "btb";
                e.rdata = '0;
                e.fault = 1'b0;
                sb.push_back(e);
                shadow[int'(addr_cur)] = data_cur;
                last_acc = addr_cur;
                addr_cur = addr_cur + 14'd1;
                data_cur = data_cur + 32'd1;
            end
        end
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        checkOutput("btb_end_ready", 64'(req_ready), 64'd1);
        checkOutput("btb_end_stall", 64'(stall), 64'd0);
        applyStimulus("btb_rd_first", 1'b0, first_acc, 32'h0, 1'b1, 1'b0);
        applyStimulus("btb_rd_last", 1'b0, last_acc, 32'h0, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_access_sequencer.md
# memory_access_sequencer

Multi-cycle data-memory port controller sitting directly downstream of the memory address handler. It accepts the resolved data address (the handler's `output_address`) plus a read/write request, drives the synchronous data RAM with the correct setup and read latency, and returns read data or a completion pulse. While an access is in flight it stalls the core. It optionally blocks user-mode accesses to protected regions.

## Interface
Parameters:
- ADDR_WIDTH, 14, RAM word-address width
- DATA_WIDTH, 32, data word width
- CODE_AREA_SIZE, 4096, first word above the code area
- USER_STACK_TOP, 6144, first word of the user stack; the privileged stack spans [CODE_AREA_SIZE, USER_STACK_TOP)
- DATA_AREA_SIZE, 8192, first invalid word address
- READ_LATENCY, 2, RAM read latency in cycles; must be ≥1

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  access request
- req_write  in  1  1 = write, 0 = read
- req_address  in  ADDR_WIDTH  word address from the address handler
- req_wdata  in  DATA_WIDTH  write data
- privilege_mode_flag  in  1  1 = privileged
- req_ready  out  1  block can accept a request
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  read result; 0 for writes and faults
- fault  out  1  qualifies resp_valid: the access was rejected
- stall  out  1  core must hold its state
- mem_address  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_WIDTH  RAM read data

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid=1, the request is accepted: req_address, req_wdata, req_write and privilege_mode_flag are registered.
  - Next state: RESP if the request faults; otherwise WRITE if req_write=1, else READ.
- WRITE:
  - mem_we=1 for exactly one cycle; mem_address and mem_wdata come from the registers.
  - Next state: RESP.
- READ:
  - mem_address is held stable.
  - A down-counter of width clog2(READ_LATENCY+1) is loaded with READ_LATENCY on entry.
  - When the counter reaches 1, mem_rdata is captured into resp_rdata and the FSM goes to RESP.
- RESP:
  - resp_valid=1 for one cycle.
  - fault is set if the request was rejected.
  - Next state: IDLE.
- There is no backpressure on the response: the consumer must take it.
- stall = (state != IDLE) or (IDLE and req_valid accepted this cycle).
- req_ready=0 in every state except IDLE.
- Faulted requests never assert mem_we and never change the RAM.
- resp_rdata is cleared to 0 on every accept and keeps its value after RESP until the next accept.
- mem_address is a registered output; it holds its last value while IDLE.
- Address compare uses the full ADDR_WIDTH value, unsigned. There is no wrap: addresses ≥ DATA_AREA_SIZE are out of range.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, fault=0, stall=0, mem_address=0, mem_wdata=0, mem_we=0.
- Reset asserted mid-access: FSM returns to IDLE at the next edge. Any pending mem_we is dropped and no resp_valid is issued.
- Latency, with accept at cycle T:
  - Write: mem_we at T+1, resp_valid at T+2.
  - Read: mem_address valid from T+1, resp_valid at T+READ_LATENCY+1.
  - Fault: resp_valid=fault=1 at T+1.
- Throughput: a new request may be accepted in the cycle after RESP. The minimum spacing between accepts is 3 cycles for writes.
- Requests with req_valid=1 while req_ready=0 are ignored; the upstream holds them.

## Configuration
- Macro `MEMORY_PROTECTION_EN`.
- Defined:
  - A request faults if address ≥ DATA_AREA_SIZE, in any mode.
  - When privilege_mode_flag=0, a request also faults if:
    - it is a write with address < CODE_AREA_SIZE, or
    - it is any access with CODE_AREA_SIZE ≤ address < USER_STACK_TOP.
- Undefined:
  - No request faults and fault is tied to 0.
  - Out-of-range addresses go to the RAM truncated to ADDR_WIDTH.

## Test plan
- Reset, then write 0xDEADBEEF to 0x1900 (privileged) → mem_we=1 for exactly one cycle at T+1 with mem_address=0x1900; resp_valid at T+2 with fault=0 and resp_rdata=0.
- Read 0x1900 with READ_LATENCY=2 and the RAM model returning 0xDEADBEEF → resp_rdata=0xDEADBEEF with resp_valid at T+3; stall high for cycles T through T+3.
- With MEMORY_PROTECTION_EN defined:
  - User-mode read of 0x1000 → fault=1 with resp_valid at T+1 and mem_we never asserted.
  - User-mode write of 0x0010 → fault=1.
  - Privileged write of 0x0010 → succeeds.
- Any-mode read of 0x2000 → fault=1 with the macro defined; with the macro undefined, fault=0 and mem_address=0x2000.
- Assert reset at T+1 of a read → no resp_valid, req_ready=1 on the following cycle, and a new write is accepted and completes normally.
- Hold req_valid high with back-to-back writes → accepts exactly every 3 cycles, and requests presented during WRITE or RESP are ignored.
